spw_rx_decoder: RTL and testbench
=================================

# spw_rx_decoder

SpaceWire receive character decoder, sitting directly downstream of the `channel` PHY's deserialised `recv` word. It accumulates 8-bit words into a bit buffer and, once aligned, emits one decoded character per cycle: data bytes, control characters and time codes. Alignment comes from hunting the first NULL. Parity, escape-sequence and buffer-overflow errors are reported to the link state machine, which owns link reset.

## Interface
Parameters:
- BUF_BITS, 24, bit-buffer depth; must be ≥ 24.

Ports:
- rx_clk_div  in  1  decoder clock; word and character rate clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- rx_word  in  8  deserialised line bits; rx_word[7] is the earliest-received bit, rx_word[0] the latest.
- rx_word_valid  in  1  rx_word holds 8 new bits. Never high on two consecutive cycles.
- char_valid  out  1  one-cycle strobe: char_data/char_is_ctrl valid.
- char_is_ctrl  out  1  1 = control character; char_data[1:0] = code (FCT 0, EOP 1, EEP 2). ESC is never emitted.
- char_data  out  8  data byte, or zero-extended control code.
- null_seen  out  1  one-cycle strobe per NULL (ESC+FCT), including the aligning NULL.
- time_valid  out  1  one-cycle strobe: time_code valid.
- time_code  out  8  time-code byte.
- locked  out  1  high in LOCKED state.
- parity_err, esc_err, ovf_err  out  1 each  one-cycle error strobes.

## Operation
- Bit buffer: shift register of BUF_BITS bits plus a fill count (5 bits).
  - Head is the oldest bit.
  - Each cycle, consumption happens first. Then, if rx_word_valid, the 8 bits are appended after the remaining bits, in order rx_word[7]..[0].
- Character format, head first:
  - Data character: P, 0, d0..d7 (10 bits).
  - Control character: P, 1, c0, c1 (4 bits); code = {c0,c1}: FCT 00, EOP 01, EEP 10, ESC 11.
- Parity: P ^ flag ^ prev_par must equal 1. prev_par is the XOR of the previous character's data bits (d0..d7) or control bits (c0,c1).
- States: HUNT, LOCKED.
- HUNT, when fill ≥ 15:
  - Test the 8 alignments k = 0..7 in parallel for NULL pattern x,1,1,1,0,1,0,0 (bit 0 don't-care).
  - On a match, take the lowest k: consume k+8 bits, set prev_par = 0 (the FCT's control bits), pulse null_seen, go to LOCKED.
  - On no match, consume 8 bits.
  - No parity checks are made in HUNT.
- LOCKED:
  - If fill ≥ 2, inspect the flag bit. Decode when fill ≥ 4 (control) or fill ≥ 10 (data); otherwise wait.
  - Decode one character per cycle and update prev_par.
  - ESC sets esc_pend; nothing is emitted for the ESC itself.
  - With esc_pend set:
    - FCT → null_seen.
    - Data character → time code.
    - ESC, EOP or EEP → esc_err.
    - esc_pend clears after the character.
  - Without esc_pend: FCT, EOP or EEP → char_valid with char_is_ctrl = 1; data character → char_valid with char_is_ctrl = 0.
- Errors:
  - Any error pulses its strobe, flushes the buffer (fill = 0, incoming word discarded), clears esc_pend and returns to HUNT.
  - parity_err takes priority over esc_err on the same character.
  - ovf_err fires when the post-consumption fill + 8 > BUF_BITS on a valid word.

## Timing
- Reset values: state HUNT; fill 0; esc_pend 0; prev_par 0; all outputs 0.
- Decode latency: a character whose last bit arrives in the word at cycle n is emitted at cycle n+1 (registered outputs). It may be later if earlier characters are still queued.
- Throughput: 1 character per cycle. Guaranteed over the 8 bits delivered per two cycles, since a word carries at most 2 control characters.
- rst asserted mid-character: the partial character is discarded and no strobe is issued.
- At most one of char_valid, null_seen, time_valid and the error strobes is high per cycle. Exception: ovf_err may coincide with a decode strobe in the same cycle.

## Configuration
- SPW_RX_TIMECODE_EN defined: ESC+data decodes to time_valid/time_code.
- SPW_RX_TIMECODE_EN undefined: ESC+data raises esc_err; time_valid and time_code are tied to 0.

## Structure
- spw_pkg holds:
  - control code constants (FCT, EOP, EEP, ESC);
  - the NULL pattern and mask;
  - character lengths (4, 10).
- Sub-module spw_char_parse: combinational head-of-buffer decode. It outputs length, class, code/byte, data parity and parity_ok; the top keeps the buffer and the FSM.

## Test plan
- NULL alignment: prepend 3 junk bits 101 to a NULL, then NULL, NULL → locked rises; null_seen ×3 (the first one is the aligning NULL); no errors.
- Data: after lock, byte 0xA5 with correct parity → char_valid = 1, char_is_ctrl = 0, char_data = 0xA5, one cycle after the word.
- Control burst: FCT, EOP, EEP packed 2 per word → char_data 0, 1, 2 on consecutive strobes, char_is_ctrl = 1, no ovf_err.
- Time code: ESC + data 0x3C → time_valid = 1, time_code = 0x3C with SPW_RX_TIMECODE_EN defined; esc_err = 1 and return to HUNT without it.
- Parity fault: flip P of a data character → parity_err pulse, locked = 0, fill = 0; a following NULL relocks.
- Escape fault and reset: ESC+EOP → esc_err; then rst asserted mid-character → all outputs 0 and state HUNT on the next cycle.

Source files
------------

// File: rtl/spw_pkg.sv
// spw_pkg: shared constants and types for the SpaceWire receive decoder.
//
// Contents:
//   CODE_*      control-character codes, value = {c0, c1}
//   NULL_PAT/NULL_MASK  ESC+FCT bit pattern. Bit j is the j-th bit from the head.
//                       Bit 0 (the ESC parity bit) is don't-care.
//   LEN_CTRL/LEN_DATA   character lengths in bits
//   rx_state_e  decoder FSM state
//   is_null()   NULL pattern match on an 8-bit head-first window
package spw_pkg;

   localparam logic [1:0] CODE_FCT = 2'b00;
   localparam logic [1:0] CODE_EOP = 2'b01;
   localparam logic [1:0] CODE_EEP = 2'b10;
   localparam logic [1:0] CODE_ESC = 2'b11;

   // Head-first pattern x,1,1,1,0,1,0,0 (bit 0 is the oldest bit).
   localparam logic [7:0] NULL_PAT  = 8'b0010_1110;
   localparam logic [7:0] NULL_MASK = 8'b1111_1110;

   localparam logic [3:0] LEN_CTRL = 4'd4;
   localparam logic [3:0] LEN_DATA = 4'd10;

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } rx_state_e;

   function automatic logic is_null(input logic [7:0] win);
      return (win & NULL_MASK) == NULL_PAT;
   endfunction

endpackage

// File: rtl/spw_char_parse.sv
// spw_char_parse: combinational decode of the character at the head of the
// bit buffer. head_i[0] is the oldest bit (P), head_i[1] is the flag.
//
// Ports:
//   head_i[9:0]   first ten buffered bits, oldest at index 0
//   prev_par_i    parity of the previous character's payload bits
//   len_o         character length (4 control, 10 data)
//   is_ctrl_o     flag bit
//   code_o        control code {c0, c1}
//   byte_o        data byte; d0 is the LSB
//   par_o         XOR of this character's payload bits
//   parity_ok_o   P ^ flag ^ prev_par == 1
module spw_char_parse
   import spw_pkg::*;
(
   input  logic [9:0] head_i,
   input  logic       prev_par_i,
   output logic [3:0] len_o,
   output logic       is_ctrl_o,
   output logic [1:0] code_o,
   output logic [7:0] byte_o,
   output logic       par_o,
   output logic       parity_ok_o
);

   assign is_ctrl_o   = head_i[1];
   assign len_o       = head_i[1] ? LEN_CTRL : LEN_DATA;
   assign code_o      = {head_i[2], head_i[3]};
   // d0 arrives first and sits at head_i[2], so the slice is already LSB-first.
   assign byte_o      = head_i[9:2];
   assign par_o       = head_i[1] ? (head_i[2] ^ head_i[3]) : (^head_i[9:2]);
   assign parity_ok_o = head_i[0] ^ head_i[1] ^ prev_par_i;

endmodule

// File: rtl/spw_rx_decoder.sv
// spw_rx_decoder: SpaceWire receive character decoder.
//
// The decoder collects 8-bit line words into a bit buffer. In HUNT it looks
// for the first NULL. In LOCKED it decodes one character per cycle.
//
// Optional feature: define SPW_RX_TIMECODE_EN to decode ESC+data as a time
// code. When it is not defined, ESC+data is an escape error and the
// time_valid/time_code outputs stay at 0.
//
// Ports:
//   rx_clk_div      decoder clock
//   rst             synchronous active-high reset
//   rx_word         8 line bits; rx_word[7] is the earliest
//   rx_word_valid   rx_word holds new bits; never high on two consecutive cycles
//   char_valid      strobe: char_data/char_is_ctrl valid
//   char_is_ctrl    1 = control character (char_data = code)
//   char_data       data byte or zero-extended control code
//   null_seen       strobe per NULL, including the aligning one
//   time_valid      strobe: time_code valid
//   time_code       time-code byte
//   locked          FSM state (1 = LOCKED)
//   parity_err, esc_err, ovf_err   error strobes
//
// Handshake: there is no back-pressure. rx_word is accepted on every cycle
// that rx_word_valid is high. Every output strobe is a one-cycle registered
// pulse, and its data outputs are valid only in that cycle.
module spw_rx_decoder
   import spw_pkg::*;
#(
   parameter int BUF_BITS = 24
) (
   input  logic       rx_clk_div,
   input  logic       rst,
   input  logic [7:0] rx_word,
   input  logic       rx_word_valid,
   output logic       char_valid,
   output logic       char_is_ctrl,
   output logic [7:0] char_data,
   output logic       null_seen,
   output logic       time_valid,
   output logic [7:0] time_code,
   output logic       locked,
   output logic       parity_err,
   output logic       esc_err,
   output logic       ovf_err
);

   // Bit i of the buffer is the i-th oldest bit. Bits at or above fill are kept at zero.
   logic [BUF_BITS-1:0] buf_q, buf_d, buf_rem;
   logic [4:0]          fill_q, fill_d, fill_rem, consume;
   rx_state_e           state_q, state_d;
   logic                esc_pend_q, esc_pend_d;
   logic                prev_par_q, prev_par_d;
   logic                flush;
   logic                hunt_hit;
   logic [2:0]          hunt_k;
   logic [7:0]          word_rev;
   logic                char_ready;

   logic       char_valid_q, char_valid_d;
   logic       char_is_ctrl_q, char_is_ctrl_d;
   logic [7:0] char_data_q, char_data_d;
   logic       null_seen_q, null_seen_d;
   logic       time_valid_q, time_valid_d;
   logic [7:0] time_code_q, time_code_d;
   logic       parity_err_q, parity_err_d;
   logic       esc_err_q, esc_err_d;
   logic       ovf_err_q, ovf_err_d;

   logic [3:0] p_len;
   logic       p_ctrl;
   logic [1:0] p_code;
   logic [7:0] p_byte;
   logic       p_par;
   logic       p_ok;

   spw_char_parse u_parse (
      .head_i      (buf_q[9:0]),
      .prev_par_i  (prev_par_q),
      .len_o       (p_len),
      .is_ctrl_o   (p_ctrl),
      .code_o      (p_code),
      .byte_o      (p_byte),
      .par_o       (p_par),
      .parity_ok_o (p_ok)
   );

   // The flag is readable once two bits are present. Any bit above fill is zero,
   // so a missing flag reads as data and the decoder waits for ten bits.
   assign char_ready = (fill_q >= 5'd2) &&
                       (p_ctrl ? (fill_q >= {1'b0, LEN_CTRL}) : (fill_q >= {1'b0, LEN_DATA}));

   always_comb begin
      state_d        = state_q;
      esc_pend_d     = esc_pend_q;
      prev_par_d     = prev_par_q;
      consume        = 5'd0;
      flush          = 1'b0;
      hunt_hit       = 1'b0;
      hunt_k         = 3'd0;
      word_rev       = 8'd0;
      char_valid_d   = 1'b0;
      char_is_ctrl_d = 1'b0;
      char_data_d    = 8'd0;
      null_seen_d    = 1'b0;
      time_valid_d   = 1'b0;
      time_code_d    = 8'd0;
      parity_err_d   = 1'b0;
      esc_err_d      = 1'b0;
      ovf_err_d      = 1'b0;

      case (state_q)
         ST_HUNT: begin
            if (fill_q >= 5'd15) begin
               // The loop runs from 7 down to 0, so the lowest matching offset is the one kept.
               for (int k = 7; k >= 0; k--) begin
                  if (is_null(buf_q[k +: 8])) begin
                     hunt_hit = 1'b1;
                     hunt_k   = 3'(k);
                  end
               end
               if (hunt_hit) begin
                  consume     = 5'(hunt_k) + 5'd8;
                  prev_par_d  = 1'b0;
                  esc_pend_d  = 1'b0;
                  null_seen_d = 1'b1;
                  state_d     = ST_LOCKED;
               end else begin
                  consume = 5'd8;
               end
            end
         end
         ST_LOCKED: begin
            if (char_ready) begin
               consume    = {1'b0, p_len};
               prev_par_d = p_par;
               esc_pend_d = 1'b0;
               if (!p_ok) begin
                  parity_err_d = 1'b1;
                  flush        = 1'b1;
               end else if (p_ctrl) begin
                  if (p_code == CODE_ESC) begin
                     if (esc_pend_q) begin
                        esc_err_d = 1'b1;
                        flush     = 1'b1;
                     end else begin
                        esc_pend_d = 1'b1;
                     end
                  end else if (esc_pend_q) begin
                     if (p_code == CODE_FCT) begin
                        null_seen_d = 1'b1;
                     end else begin
                        esc_err_d = 1'b1;
                        flush     = 1'b1;
                     end
                  end else begin
                     char_valid_d   = 1'b1;
                     char_is_ctrl_d = 1'b1;
                     char_data_d    = {6'd0, p_code};
                  end
               end else if (esc_pend_q) begin
`ifdef SPW_RX_TIMECODE_EN
                  time_valid_d = 1'b1;
                  time_code_d  = p_byte;
`else
                  esc_err_d = 1'b1;
                  flush     = 1'b1;
`endif
               end else begin
                  char_valid_d = 1'b1;
                  char_data_d  = p_byte;
               end
            end
         end
         default: state_d = ST_HUNT;
      endcase

      // Consumption happens first. The new word is then appended after the bits that remain.
      fill_rem = fill_q - consume;
      buf_rem  = buf_q >> consume;
      for (int i = 0; i < 8; i++) begin
         word_rev[i] = rx_word[7-i];
      end

      if (!flush && rx_word_valid && (int'(fill_rem) + 8 > BUF_BITS)) begin
         ovf_err_d = 1'b1;
         flush     = 1'b1;
      end

      if (flush) begin
         buf_d      = '0;
         fill_d     = 5'd0;
         state_d    = ST_HUNT;
         esc_pend_d = 1'b0;
      end else if (rx_word_valid) begin
         buf_d  = buf_rem | (BUF_BITS'(word_rev) << fill_rem);
         fill_d = fill_rem + 5'd8;
      end else begin
         buf_d  = buf_rem;
         fill_d = fill_rem;
      end
   end

   always_ff @(posedge rx_clk_div) begin
      if (rst) begin
         buf_q          <= '0;
         fill_q         <= 5'd0;
         state_q        <= ST_HUNT;
         esc_pend_q     <= 1'b0;
         prev_par_q     <= 1'b0;
         char_valid_q   <= 1'b0;
         char_is_ctrl_q <= 1'b0;
         char_data_q    <= 8'd0;
         null_seen_q    <= 1'b0;
         time_valid_q   <= 1'b0;
         time_code_q    <= 8'd0;
         parity_err_q   <= 1'b0;
         esc_err_q      <= 1'b0;
         ovf_err_q      <= 1'b0;
      end else begin
         buf_q          <= buf_d;
         fill_q         <= fill_d;
         state_q        <= state_d;
         esc_pend_q     <= esc_pend_d;
         prev_par_q     <= prev_par_d;
         char_valid_q   <= char_valid_d;
         char_is_ctrl_q <= char_is_ctrl_d;
         char_data_q    <= char_data_d;
         null_seen_q    <= null_seen_d;
         time_valid_q   <= time_valid_d;
         time_code_q    <= time_code_d;
         parity_err_q   <= parity_err_d;
         esc_err_q      <= esc_err_d;
         ovf_err_q      <= ovf_err_d;
      end
   end

   assign char_valid   = char_valid_q;
   assign char_is_ctrl = char_is_ctrl_q;
   assign char_data    = char_data_q;
   assign null_seen    = null_seen_q;
   assign time_valid   = time_valid_q;
   assign time_code    = time_code_q;
   assign parity_err   = parity_err_q;
   assign esc_err      = esc_err_q;
   assign ovf_err      = ovf_err_q;
   assign locked       = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_spw_rx_decoder.sv
// tb_spw_rx_decoder: self-checking bench for spw_rx_decoder.
// The stimulus is a character-level bit stream. A bit-queue reference model
// produces the expected event list, and a monitor compares each output strobe
// against that list.
module tb_spw_rx_decoder;

   logic       clk;
   logic       rst;
   logic [7:0] rx_word;
   logic       rx_word_valid;
   logic       char_valid, char_is_ctrl, null_seen, time_valid, locked;
   logic       parity_err, esc_err, ovf_err;
   logic [7:0] char_data, time_code;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   spw_rx_decoder #(.BUF_BITS(24)) dut (
      .rx_clk_div    (clk),
      .rst           (rst),
      .rx_word       (rx_word),
      .rx_word_valid (rx_word_valid),
      .char_valid    (char_valid),
      .char_is_ctrl  (char_is_ctrl),
      .char_data     (char_data),
      .null_seen     (null_seen),
      .time_valid    (time_valid),
      .time_code     (time_code),
      .locked        (locked),
      .parity_err    (parity_err),
      .esc_err       (esc_err),
      .ovf_err       (ovf_err)
   );

   localparam int EV_DATA = 0, EV_CTRL = 1, EV_NULL = 2, EV_TIME = 3;
   localparam int EV_PERR = 4, EV_EERR = 5, EV_OVF = 6;

   logic [11:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   bit mq[$];        // model: bits held by the receiver, oldest first
   bit m_locked, m_prev, m_esc, m_err;
   bit txq[$];       // characters encoded but not yet sent
   bit tx_prev;
   bit need_relock;
   int r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_ev(input int kind, input logic [7:0] d);
      exp_q.push_back({kind[3:0], d});
   endtask

   // ---------------- encoder ----------------
   task automatic put_char(input bit is_ctrl, input logic [7:0] val, input bit flip);
      bit par;
      par = is_ctrl ? (val[1] ^ val[0]) : (^val);
      txq.push_back(1'b1 ^ is_ctrl ^ tx_prev ^ flip);
      txq.push_back(is_ctrl);
      if (is_ctrl) begin
         txq.push_back(val[1]);
         txq.push_back(val[0]);
      end else begin
         for (int i = 0; i < 8; i++) txq.push_back(val[i]);
      end
      tx_prev = par;
   endtask

   task automatic put_null();
      put_char(1'b1, 8'd3, 1'b0);
      put_char(1'b1, 8'd0, 1'b0);
   endtask

   task automatic pad_tx();
      while (txq.size() % 8 != 0) txq.push_back(1'b0);
   endtask

   // ---------------- reference model ----------------
   task automatic model_error(input int kind);
      push_ev(kind, 8'd0);
      m_locked = 0;
      m_esc    = 0;
      mq.delete();
      m_err    = 1;
   endtask

   task automatic model_run();
      bit busy, flag, par;
      int hit, len;
      logic [1:0] code;
      logic [7:0] b;
      busy = 1;
      while (busy) begin
         busy = 0;
         if (!m_locked) begin
            if (mq.size() >= 15) begin
               busy = 1;
               hit  = -1;
               for (int k = 0; k < 8; k++)
                  if (hit < 0 && mq[k+1] && mq[k+2] && mq[k+3] && !mq[k+4] &&
                      mq[k+5] && !mq[k+6] && !mq[k+7]) hit = k;
               repeat ((hit < 0) ? 8 : hit + 8) void'(mq.pop_front());
               if (hit >= 0) begin
                  m_locked = 1;
                  m_prev   = 0;
                  m_esc    = 0;
                  push_ev(EV_NULL, 8'd0);
               end
            end
         end else if (mq.size() >= 2) begin
            flag = mq[1];
            len  = flag ? 4 : 10;
            if (mq.size() >= len) begin
               busy = 1;
               b    = '0;
               code = '0;
               if (flag) code = {mq[2], mq[3]};
               else for (int i = 0; i < 8; i++) b[i] = mq[2+i];
               par = flag ? (code[1] ^ code[0]) : (^b);
               if ((mq[0] ^ flag ^ m_prev) != 1'b1) begin
                  model_error(EV_PERR);
               end else begin
                  m_prev = par;
                  repeat (len) void'(mq.pop_front());
                  if (flag && code == 2'd3) begin
                     if (m_esc) model_error(EV_EERR);
                     else m_esc = 1;
                  end else if (m_esc) begin
                     m_esc = 0;
                     if (flag && code == 2'd0) push_ev(EV_NULL, 8'd0);
                     else if (flag) model_error(EV_EERR);
                     else begin
`ifdef SPW_RX_TIMECODE_EN
                        push_ev(EV_TIME, b);
`else
                        model_error(EV_EERR);
`endif
                     end
                  end else if (flag) begin
                     push_ev(EV_CTRL, {6'd0, code});
                  end else begin
                     push_ev(EV_DATA, b);
                  end
               end
            end
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic send_word();
      logic [7:0] w;
      for (int i = 0; i < 8; i++) begin
         w[7-i] = txq.pop_front();
         mq.push_back(w[7-i]);
      end
      @(negedge clk);
      rx_word       = w;
      rx_word_valid = 1'b1;
      model_run();
      @(negedge clk);
      rx_word_valid = 1'b0;
      rx_word       = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (m_err) begin
         // The receiver flushes on the error, so bits not yet sent are dropped.
         txq.delete();
         m_err       = 0;
         need_relock = 1;
         repeat (12) @(negedge clk);
      end
   endtask

   task automatic flush_tx();
      while (txq.size() >= 8) send_word();
   endtask

   task automatic settle();
      repeat (10) @(negedge clk);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [11:0] obs;
      int n;
      if (!rst) begin
         n = int'(char_valid) + int'(null_seen) + int'(time_valid) +
             int'(parity_err) + int'(esc_err) + int'(ovf_err);
         if (n > 1) check("one_strobe", n, 1);
         obs = '0;
         if (char_valid)      obs = {char_is_ctrl ? 4'(EV_CTRL) : 4'(EV_DATA), char_data};
         else if (null_seen)  obs = {4'(EV_NULL), 8'd0};
         else if (time_valid) obs = {4'(EV_TIME), time_code};
         else if (parity_err) obs = {4'(EV_PERR), 8'd0};
         else if (esc_err)    obs = {4'(EV_EERR), 8'd0};
         else if (ovf_err)    obs = {4'(EV_OVF), 8'd0};
         if (n != 0) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_event actual=%0h required=none", obs);
            end else begin
               check("event", obs, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; rx_word = 8'd0; rx_word_valid = 1'b0;
      m_locked = 0; m_prev = 0; m_esc = 0; m_err = 0; tx_prev = 0; need_relock = 0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {char_valid, char_is_ctrl, char_data, null_seen, time_valid,
                              time_code, parity_err, esc_err, ovf_err}, 0);
      check("reset_locked", locked, 0);
      rst = 1'b0;

      // Three junk bits, then three NULLs.
      txq.push_back(1'b1); txq.push_back(1'b0); txq.push_back(1'b1);
      put_null(); put_null(); put_null();
      flush_tx(); settle();
      check("lock_after_null", locked, 1);

      // A data byte, a control burst, then ESC + data.
      put_char(1'b0, 8'hA5, 1'b0);
      put_char(1'b1, 8'd0, 1'b0); put_char(1'b1, 8'd1, 1'b0); put_char(1'b1, 8'd2, 1'b0);
      put_char(1'b1, 8'd3, 1'b0); put_char(1'b0, 8'h3C, 1'b0);
      pad_tx(); flush_tx(); settle();
`ifdef SPW_RX_TIMECODE_EN
      check("timecode_lock", locked, 1);
`else
      check("timecode_lock", locked, 0);
`endif

      // Relock, then a data character with a corrupted parity bit.
      put_null(); put_null(); flush_tx(); settle();
      check("relock1", locked, 1);
      put_char(1'b0, 8'h5A, 1'b1); pad_tx(); flush_tx(); settle();
      check("parity_unlock", locked, 0);

      // Relock after the parity fault, then ESC+EOP.
      put_null(); put_null(); flush_tx(); settle();
      check("relock2", locked, 1);
      put_char(1'b1, 8'd3, 1'b0); put_char(1'b1, 8'd1, 1'b0); pad_tx(); flush_tx(); settle();
      check("esc_unlock", locked, 0);

      // Relock, then assert reset partway through a data character.
      put_null(); put_null(); put_char(1'b0, 8'hC3, 1'b0);
      flush_tx(); settle();
      check("relock3", locked, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_outputs", {char_valid, null_seen, time_valid, parity_err, esc_err, ovf_err}, 0);
      check("rst_locked", locked, 0);
      rst = 1'b0;
      txq.delete(); mq.delete();
      m_locked = 0; m_esc = 0; m_prev = 0; need_relock = 0;

      // Random character stream.
      put_null(); put_null();
      for (int it = 0; it < 300; it++) begin
         if (need_relock) begin
            put_null(); put_null();
            need_relock = 0;
         end
         r = $urandom_range(0, 99);
         if (r < 40) put_char(1'b0, 8'($urandom), 1'b0);
         else if (r < 70) put_char(1'b1, 8'($urandom_range(0, 2)), 1'b0);
         else if (r < 80) put_null();
         else if (r < 88) begin
            put_char(1'b1, 8'd3, 1'b0);
            put_char(1'b0, 8'($urandom), 1'b0);
         end else if (r < 93) begin
            if ($urandom_range(0, 1) == 0) put_char(1'b0, 8'($urandom), 1'b1);
            else put_char(1'b1, 8'($urandom_range(0, 3)), 1'b1);
         end else begin
            put_char(1'b1, 8'd3, 1'b0);
            put_char(1'b1, 8'($urandom_range(1, 3)), 1'b0);
         end
         flush_tx();
      end
      repeat (30) @(negedge clk);
      check("final_locked", locked, m_locked);
      check("drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
